// File: rtl/multiword_add_seq.sv
// multiword_add_seq: performs one WORDS x WIDTH-bit addition by time-sharing a
// single external WIDTH-bit combinational adder, one word per cycle, least
// significant word first, with the inter-word carry held in a register.
// Optional feature macro: ADD_SEQ_SUB_EN adds a 'sub' port that turns the
// operation into A - B (two's complement: ~B with a forced carry-in of 1).
module multiword_add_seq #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WORDS*WIDTH-1:0] A,
    input  logic [WORDS*WIDTH-1:0] B,
    input  logic                   Cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [WORDS*WIDTH-1:0] Sum,
    output logic                   Cout,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_sum,
    input  logic                   add_cout
);

    localparam int OPW  = WORDS * WIDTH;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [OPW-1:0]    a_q, a_d;
    logic [OPW-1:0]    b_q, b_d;
    logic              cin_q, cin_d;
    logic [OPW-1:0]    sum_q, sum_d;
    logic              cout_q, cout_d;

    logic [WIDTH-1:0]  a_word;
    logic [WIDTH-1:0]  b_word;
    logic              sub_eff;

`ifdef ADD_SEQ_SUB_EN
    logic              sub_q, sub_d;

    // Subtract flag is captured together with the operands on accept.
    always_comb begin
        sub_d = sub_q;
        if (state_q == ST_IDLE && start) begin
            sub_d = sub;
        end
    end

    // Subtract flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end

    assign sub_eff = sub_q;
`else
    assign sub_eff = 1'b0;
`endif

    // Select the operand words addressed by the current word index.
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_word = a_q[k*WIDTH +: WIDTH];
                b_word = b_q[k*WIDTH +: WIDTH];
            end
        end
    end

    // Drive the shared adder only while running; zero otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == ST_RUN) begin
            add_a = a_word;
            add_b = sub_eff ? ~b_word : b_word;
            if (idx_q == '0) begin
                add_cin = sub_eff ? 1'b1 : cin_q;
            end else begin
                add_cin = carry_q;
            end
        end
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    cin_d   = Cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int unsigned k = 0; k < WORDS; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        sum_d[k*WIDTH +: WIDTH] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (idx_q == IDX_LAST) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq (WORDS=4, WIDTH=32) with a
// behavioural model of the external 32-bit adder.
module tb_multiword_add_seq;

    localparam int WIDTH = 32;
    localparam int WORDS = 4;
    localparam int OPW   = WORDS * WIDTH;

    logic             clk;
    logic             rst;
    logic             start;
    logic [OPW-1:0]   A;
    logic [OPW-1:0]   B;
    logic             Cin;
`ifdef ADD_SEQ_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [OPW-1:0]   Sum;
    logic             Cout;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    int checks = 0;
    int errors = 0;

    logic [OPW:0] exp_q[$];
    logic         cin_trace[0:7];
    int           busy_cycles;
    int           latency;

    multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
`ifdef ADD_SEQ_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .Sum      (Sum),
        .Cout     (Cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // External combinational 32-bit full adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [OPW:0] act, input logic [OPW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                chk("result", {Cout, Sum}, exp_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) chk("idle_timeout", 1, 0);
    endtask

    // Issue one operation and follow it to done, recording add_cin per RUN cycle.
    task automatic run_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                          input logic c, input logic sb, input logic [OPW:0] exp);
        wait_idle();
        A     = a;
        B     = b;
        Cin   = c;
`ifdef ADD_SEQ_SUB_EN
        sub   = sb;
`endif
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start       = 1'b0;
        A           = '1;
        B           = '1;
        busy_cycles = 0;
        latency     = 0;
        for (int i = 0; i < 8; i++) cin_trace[i] = 1'bx;
        while (latency < 20) begin
            @(negedge clk);
            latency++;
            if (busy) begin
                if (busy_cycles < 8) cin_trace[busy_cycles] = add_cin;
                busy_cycles++;
            end
            if (done) break;
        end
        if (!done) chk("done_timeout", 0, 1);
        chk("busy_cycles", OPW'(busy_cycles), OPW'(WORDS));
        chk("done_latency", OPW'(latency), OPW'(WORDS + 1));
        if (sb) begin end
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Cin   = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_busy", OPW'(busy), 0);
        chk("reset_done", OPW'(done), 0);
        chk("reset_sum_cout", {Cout, Sum}, 0);
        chk("reset_add_bus", {add_cin, add_b, add_a}, 0);
        rst = 1'b0;

        // Basic add
        run_op(128'd5465, 128'd52, 1'b0, 1'b0, {1'b0, 128'd5517});
        chk("basic_cin_trace", {cin_trace[0], cin_trace[1], cin_trace[2], cin_trace[3]}, 0);
        chk("idle_add_bus", {add_cin, add_b, add_a}, 0);

        // Inter-word carry
        run_op(128'h00000000_00000000_00000000_FFFFFFFF, 128'd1, 1'b0, 1'b0,
               {1'b0, 128'h00000000_00000000_00000001_00000000});
        chk("carry_cin_trace", {cin_trace[0], cin_trace[1], cin_trace[2], cin_trace[3]}, 4'b0100);

        // Full overflow with Cin, then a small add with Cin
        run_op('1, 128'd0, 1'b1, 1'b0, {1'b1, 128'd0});
        chk("ovf_cin_trace", {cin_trace[0], cin_trace[1], cin_trace[2], cin_trace[3]}, 4'b1111);
        run_op(128'd8, 128'd5254, 1'b1, 1'b0, {1'b0, 128'd5263});

        // Start held through RUN with A changed after accept
        wait_idle();
        A     = 128'd5;
        B     = 128'd2;
        Cin   = 1'b0;
        start = 1'b1;
        exp_q.push_back({1'b0, 128'd7});
        @(posedge clk);
        #1;
        A = 128'd100;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        if (!done) chk("held_done_timeout", 0, 1);
        exp_q.push_back({1'b0, 128'd102});
        @(negedge clk);
        chk("held_single_done", OPW'(done), 0);
        chk("held_idle_after_done", OPW'(busy), 0);
        @(negedge clk);
        chk("held_reaccept", OPW'(busy), 1);
        start = 1'b0;
        wait_idle();

        // Reset during the idx=2 cycle
        A     = 128'h00000003_00000002_00000001_00000007;
        B     = 128'd0;
        Cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", OPW'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", OPW'(busy), 0);
        chk("midrst_sum_cout", {Cout, Sum}, 0);
        repeat (3) @(negedge clk);
        chk("midrst_no_done", OPW'(done), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_no_done", OPW'(done), 0);
        run_op(128'd245, 128'd52, 1'b0, 1'b0, {1'b0, 128'd297});

`ifdef ADD_SEQ_SUB_EN
        run_op(128'd5, 128'd2, 1'b0, 1'b1, {1'b1, 128'd3});
        run_op(128'd2, 128'd5, 1'b0, 1'b1,
               {1'b0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFD});
        run_op(128'd10, 128'd10, 1'b0, 1'b1, {1'b1, 128'd0});
        chk("sub_forced_cin", OPW'(cin_trace[0]), 1);
        run_op(128'd5, 128'd2, 1'b1, 1'b0, {1'b0, 128'd8});
`endif

        wait_idle();
        repeat (2) @(negedge clk);
        chk("queue_empty", OPW'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
